// File: rtl/ws2812_chain.sv
// WS2812/WS2812B serial LED-chain driver: fetches NUM_LEDS GRB pixels from an
// external store, scales them by a frame-latched brightness and bit-bangs them.
module ws2812_chain #(
  parameter  int NUM_LEDS  = 256,
  parameter  int T0H_CYC   = 10,
  parameter  int T1H_CYC   = 20,
  parameter  int BIT_CYC   = 31,
  parameter  int RESET_CYC = 2000,
  localparam int ADDR_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              auto_refresh,
  input  logic [7:0]        brightness,
  output logic              pix_req,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic              o_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int K_W = $clog2(BIT_CYC);
  localparam int L_W = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;
  localparam logic [K_W-1:0]    K_LAST   = K_W'(BIT_CYC - 1);
  localparam logic [L_W-1:0]    L_LAST   = L_W'(RESET_CYC - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAPTURE,
    S_SEND,
    S_LATCH
  } state_t;

  state_t            state_reg;
  logic [7:0]        bright_reg;
  logic [K_W-1:0]    k_reg;
  logic [4:0]        bit_reg;
  logic [ADDR_W-1:0] pix_cnt_reg;
  logic [L_W-1:0]    lat_cnt_reg;
  logic [23:0]       shift_reg;
  logic [23:0]       hold_reg;
  logic              cap_pend_reg;
  logic              pix_req_reg;
  logic [ADDR_W-1:0] pix_addr_reg;
  logic              o_out_reg;
  logic              busy_reg;
  logic              frame_done_reg;

  // (c * (b + 1)) >> 8 keeps 255 as an exact passthrough and 0 as black.
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [8:0] b1);
    logic [15:0] p;
    p = {8'd0, c} * {7'd0, b1};
    return 8'(p >> 8);
  endfunction

  logic [8:0]  bright_p1;
  logic [23:0] scaled;
  assign bright_p1 = {1'b0, bright_reg} + 9'd1;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign scaled[gi*8 +: 8] = scale8(pix_data[gi*8 +: 8], bright_p1);
    end
  endgenerate

  logic [K_W:0] k_inc;
  logic         hi_next;
  logic         bit_end;
  logic         pix_end;
  logic [23:0]  next_pix;

  assign k_inc    = {1'b0, k_reg} + (K_W+1)'(1);
  assign hi_next  = shift_reg[23] ? (k_inc < (K_W+1)'(T1H_CYC)) : (k_inc < (K_W+1)'(T0H_CYC));
  assign bit_end  = (k_reg == K_LAST);
  assign pix_end  = bit_end && (bit_reg == 5'd23);
  // Bypass the holding register when the prefetched word lands on the boundary edge.
  assign next_pix = cap_pend_reg ? scaled : hold_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      bright_reg     <= 8'd0;
      k_reg          <= '0;
      bit_reg        <= 5'd0;
      pix_cnt_reg    <= '0;
      lat_cnt_reg    <= '0;
      shift_reg      <= 24'd0;
      hold_reg       <= 24'd0;
      cap_pend_reg   <= 1'b0;
      pix_req_reg    <= 1'b0;
      pix_addr_reg   <= '0;
      o_out_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      pix_req_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      cap_pend_reg   <= pix_req_reg;
      if (cap_pend_reg) hold_reg <= scaled;

      case (state_reg)
        S_IDLE: begin
          o_out_reg <= 1'b0;
          busy_reg  <= 1'b0;
          if (start) begin
            bright_reg   <= brightness;
            state_reg    <= S_LOAD;
            pix_req_reg  <= 1'b1;
            pix_addr_reg <= '0;
            busy_reg     <= 1'b1;
          end
        end
        S_LOAD: state_reg <= S_CAPTURE;
        S_CAPTURE: begin
          shift_reg   <= scaled;
          state_reg   <= S_SEND;
          k_reg       <= '0;
          bit_reg     <= 5'd0;
          pix_cnt_reg <= '0;
          o_out_reg   <= 1'b1;
        end
        S_SEND: begin
          if (!bit_end) begin
            k_reg     <= k_inc[K_W-1:0];
            o_out_reg <= hi_next;
          end else begin
            k_reg <= '0;
            if (pix_end) begin
              if (pix_cnt_reg == PIX_LAST) begin
                state_reg      <= S_LATCH;
                lat_cnt_reg    <= '0;
                o_out_reg      <= 1'b0;
                frame_done_reg <= (RESET_CYC == 1);
              end else begin
                shift_reg   <= next_pix;
                bit_reg     <= 5'd0;
                pix_cnt_reg <= pix_cnt_reg + ADDR_W'(1);
                o_out_reg   <= 1'b1;
              end
            end else begin
              shift_reg <= {shift_reg[22:0], 1'b0};
              bit_reg   <= bit_reg + 5'd1;
              o_out_reg <= 1'b1;
              // Entering the final bit of a non-last pixel: fetch the next one.
              if (bit_reg == 5'd22 && pix_cnt_reg != PIX_LAST) begin
                pix_req_reg  <= 1'b1;
                pix_addr_reg <= pix_cnt_reg + ADDR_W'(1);
              end
            end
          end
        end
        S_LATCH: begin
          o_out_reg <= 1'b0;
          if (lat_cnt_reg == L_LAST) begin
            if (auto_refresh) begin
              bright_reg   <= brightness;
              state_reg    <= S_LOAD;
              pix_req_reg  <= 1'b1;
              pix_addr_reg <= '0;
            end else begin
              state_reg <= S_IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            lat_cnt_reg    <= lat_cnt_reg + L_W'(1);
            frame_done_reg <= (lat_cnt_reg + L_W'(1) == L_LAST);
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign pix_req    = pix_req_reg;
  assign pix_addr   = pix_addr_reg;
  assign o_out      = o_out_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_ws2812_chain.sv
// Bench for ws2812_chain: decodes the serial line back into pixels and checks
// them against a queue of expected values, plus cycle-exact timeline checks.
module tb_ws2812_chain;

  localparam int N    = 2;
  localparam int T0H  = 2;
  localparam int T1H  = 4;
  localparam int BITC = 6;
  localparam int RSTC = 10;
  localparam int FP   = 300;
  localparam int PREF = 3 + 23 * BITC;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        auto_refresh;
  logic [7:0]  brightness;
  logic        pix_req;
  logic [0:0]  pix_addr;
  logic [23:0] pix_data;
  logic        o_out;
  logic        busy;
  logic        frame_done;

  ws2812_chain #(
    .NUM_LEDS(N), .T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BITC), .RESET_CYC(RSTC)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .auto_refresh(auto_refresh),
    .brightness(brightness), .pix_req(pix_req), .pix_addr(pix_addr),
    .pix_data(pix_data), .o_out(o_out), .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  logic [23:0] mem [0:1];
  always @(posedge clock) if (pix_req) pix_data <= mem[pix_addr];

  int n_cmp = 0;
  int n_bad = 0;
  logic [23:0] exp_q[$];
  logic [23:0] wexp [0:5];

  logic tr_out  [0:999];
  logic tr_req  [0:999];
  logic tr_addr [0:999];
  logic tr_busy [0:999];
  logic tr_done [0:999];

  typedef struct {
    logic [23:0] p0;
    logic [23:0] p1;
    logic [7:0]  br;
    logic [23:0] e0;
    logic [23:0] e1;
  } vec_t;
  vec_t tbl [0:5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line decoder: pulse width picks the bit value, 24 bits form a pixel.
  initial begin
    int hi_len;
    int nb;
    logic prev;
    logic [23:0] sh;
    logic [23:0] want;
    hi_len = 0; nb = 0; prev = 1'b0; sh = 24'd0;
    forever begin
      @(negedge clock);
      if (busy !== 1'b1) begin
        hi_len = 0; nb = 0; prev = 1'b0;
      end else begin
        if (o_out === 1'b1) hi_len++;
        else if (prev) begin
          if (hi_len == T1H) sh = {sh[22:0], 1'b1};
          else if (hi_len == T0H) sh = {sh[22:0], 1'b0};
          else begin
            n_cmp++; n_bad++;
            $display("FAIL pulse width: got %0d cycles expected %0d or %0d", hi_len, T0H, T1H);
            sh = {sh[22:0], 1'b0};
          end
          hi_len = 0;
          nb++;
          if (nb == 24) begin
            nb = 0;
            if (exp_q.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL unexpected pixel: got %06h expected none", sh);
            end else begin
              want = exp_q.pop_front();
              n_cmp++;
              if (sh !== want) begin
                n_bad++;
                $display("FAIL pixel: got %06h expected %06h", sh, want);
              end else
                $display("pixel got %06h expected %06h ok", sh, want);
            end
          end
        end
        prev = (o_out === 1'b1);
      end
    end
  end

  // start is pulsed in cycle 0; optional extra start/reset pulses and input changes.
  task automatic run_frame(input int ncyc, input logic ar0, input int ar_off_at,
                           input logic [7:0] br0, input int br_at, input logic [7:0] br1,
                           input int s2_at, input int s3_at, input int rst_at);
    @(negedge clock);
    auto_refresh = ar0; brightness = br0; start = 1'b1;
    tr_out[0] = o_out; tr_req[0] = pix_req; tr_addr[0] = pix_addr[0];
    tr_busy[0] = busy; tr_done[0] = frame_done;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clock);
      start = (i == s2_at) || (i == s3_at);
      reset = (i == rst_at);
      if (i == ar_off_at) auto_refresh = 1'b0;
      if (i == br_at) brightness = br1;
      tr_out[i] = o_out; tr_req[i] = pix_req; tr_addr[i] = pix_addr[0];
      tr_busy[i] = busy; tr_done[i] = frame_done;
    end
    start = 1'b0; reset = 1'b0; auto_refresh = 1'b0;
  endtask

  task automatic check_wave(input int nfr, input int last);
    int bad;
    bad = 0;
    for (int c = 0; c <= last; c++) begin
      logic e;
      int f, rel, t, b, k;
      logic [23:0] px;
      e = 1'b0; f = c / FP; rel = c - FP * f;
      if (f < nfr && rel >= 3 && rel < 3 + 48 * BITC) begin
        t = rel - 3; b = t / BITC; k = t % BITC;
        px = wexp[2 * f + b / 24];
        e = px[23 - (b % 24)] ? (k < T1H) : (k < T0H);
      end
      if (tr_out[c] !== e) bad++;
    end
    check("o_out waveform errors", bad, 0);
  endtask

  task automatic check_timeline(input int nfr, input int last);
    int br, ba, bb, bd, bc;
    br = 0; ba = 0; bb = 0; bd = 0; bc = 0;
    for (int c = 0; c <= last; c++) begin
      logic er, ea, ed, eb;
      er = 1'b0; ea = 1'b0; ed = 1'b0;
      for (int f = 0; f < nfr; f++) begin
        if (c == FP * f + 1) er = 1'b1;
        if (c == FP * f + PREF) begin er = 1'b1; ea = 1'b1; end
        if (c == FP * (f + 1)) ed = 1'b1;
      end
      eb = (c >= 1) && (c <= FP * nfr);
      if (tr_req[c] !== er) br++;
      if (er && tr_addr[c] !== ea) ba++;
      if (tr_busy[c] !== eb) bb++;
      if (tr_done[c] !== ed) bd++;
      if (c > 0 && tr_req[c] && tr_req[c-1]) bc++;
    end
    check("pix_req timeline errors", br, 0);
    check("pix_addr errors", ba, 0);
    check("busy timeline errors", bb, 0);
    check("frame_done timeline errors", bd, 0);
    check("back-to-back pix_req", bc, 0);
  endtask

  task automatic table_frame(input int r);
    mem[0] = tbl[r].p0; mem[1] = tbl[r].p1;
    wexp[0] = tbl[r].e0; wexp[1] = tbl[r].e1;
    exp_q.push_back(tbl[r].e0); exp_q.push_back(tbl[r].e1);
    run_frame(310, 1'b0, -1, tbl[r].br, -1, 8'd0, -1, -1, -1);
    check_wave(1, 310);
    check_timeline(1, 310);
  endtask

  initial begin
    tbl[0] = '{24'hFF0000, 24'h000001, 8'd255, 24'hFF0000, 24'h000001};
    tbl[1] = '{24'hFF8001, 24'h123456, 8'd127, 24'h7F4000, 24'h091A2B};
    tbl[2] = '{24'hFF8001, 24'hFFFFFF, 8'd0,   24'h000000, 24'h000000};
    tbl[3] = '{24'h808080, 24'hFFFFFF, 8'd63,  24'h202020, 24'h3F3F3F};
    tbl[4] = '{24'hC8647F, 24'hFFFFFF, 8'd1,   24'h010000, 24'h010101};
    tbl[5] = '{24'hC8647F, 24'h000000, 8'd199, 24'h9C4E63, 24'h000000};

    reset = 1'b1; start = 1'b0; auto_refresh = 1'b0; brightness = 8'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset o_out", o_out, 0);
    check("reset busy", busy, 0);
    check("reset pix_req", pix_req, 0);
    check("reset pix_addr", pix_addr, 0);
    check("reset frame_done", frame_done, 0);

    for (int r = 0; r < 6; r++) table_frame(r);

    // start pulses while busy, including on the frame_done cycle
    mem[0] = 24'hFF0000; mem[1] = 24'h000001;
    wexp[0] = 24'hFF0000; wexp[1] = 24'h000001;
    exp_q.push_back(24'hFF0000); exp_q.push_back(24'h000001);
    run_frame(310, 1'b0, -1, 8'd255, -1, 8'd0, 50, 300, -1);
    check_wave(1, 310);
    check_timeline(1, 310);

    // reset in mid-frame
    exp_q.push_back(24'hFF0000); exp_q.push_back(24'h000001);
    run_frame(200, 1'b0, -1, 8'd255, -1, 8'd0, -1, -1, 100);
    check("busy before reset", tr_busy[99], 1);
    check("o_out after reset", tr_out[101], 0);
    check("busy after reset", tr_busy[101], 0);
    check("pix_req after reset", tr_req[101], 0);
    check("pix_addr after reset", tr_addr[101], 0);
    begin
      int nd, nb;
      nd = 0; nb = 0;
      for (int c = 101; c <= 200; c++) begin
        if (tr_done[c]) nd++;
        if (tr_busy[c]) nb++;
      end
      check("frame_done after abort", nd, 0);
      check("busy cycles after abort", nb, 0);
    end
    exp_q.delete();
    table_frame(1);

    // auto refresh: three frames back to back
    mem[0] = 24'h123456; mem[1] = 24'hA5C30F;
    for (int f = 0; f < 3; f++) begin
      wexp[2*f] = 24'h123456; wexp[2*f+1] = 24'hA5C30F;
      exp_q.push_back(24'h123456); exp_q.push_back(24'hA5C30F);
    end
    run_frame(910, 1'b1, 850, 8'd255, -1, 8'd0, -1, -1, -1);
    check_wave(3, 910);
    check_timeline(3, 910);

    // brightness latched per frame
    mem[0] = 24'hFF8001; mem[1] = 24'h123456;
    wexp[0] = 24'hFF8001; wexp[1] = 24'h123456; wexp[2] = 24'h0; wexp[3] = 24'h0;
    exp_q.push_back(24'hFF8001); exp_q.push_back(24'h123456);
    exp_q.push_back(24'h000000); exp_q.push_back(24'h000000);
    run_frame(610, 1'b1, 350, 8'd255, 10, 8'd0, -1, -1, -1);
    check_wave(2, 610);
    check_timeline(2, 610);

    check("pixels left undelivered", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
